pc_fetch_unit: RTL and testbench

Registered fetch-stage program counter with next-PC selection, an instruction-memory request/ready handshake, a pending-redirect buffer and exception/ERET redirection. It sits at the front of the five-stage MIPS pipeline. It owns `F_PC`, takes branch/jump resolution from the D stage, stall from the hazard unit, and exception/ERET requests from the M-stage CP0. Generalised over address width, reset/handler vectors and the legal instruction-memory window.

---
 rtl/pc_fetch_unit_pkg.sv | 26 ++
 rtl/pc_fetch_unit_npc_target.sv | 69 ++++++
 rtl/pc_fetch_unit.sv | 112 +++++++++++
 tb/tb_pc_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg : shared encodings for the fetch-stage PC logic.
//   pcsel_e : D-stage next-PC selector (normal, conditional branches,
//             jump, jump-register).
//   CMP_*   : two-bit compare result codes produced by the D-stage
//             comparators (rs vs rt, rs vs zero).
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [3:0] {
        PCSEL_NORMAL = 4'd0,
        PCSEL_BEQ    = 4'd1,
        PCSEL_BNE    = 4'd2,
        PCSEL_BGEZ   = 4'd3,
        PCSEL_BGTZ   = 4'd4,
        PCSEL_BLEZ   = 4'd5,
        PCSEL_BLTZ   = 4'd6,
        PCSEL_JUMP   = 4'd7,
        PCSEL_JREG   = 4'd8
    } pcsel_e;

    localparam logic [1:0] CMP_EQUAL = 2'b00;
    localparam logic [1:0] CMP_BIG   = 2'b01;
    localparam logic [1:0] CMP_LESS  = 2'b10;

endpackage

// File: rtl/pc_fetch_unit_npc_target.sv
// ---------------------------------------------------------------------------
// npc_target : combinational redirect evaluation for the D-stage instruction.
//   i_enable    : D holds a real instruction and the pipe is not stalled
//   i_pcsel     : next-PC selector (pc_pkg::pcsel_e encoding)
//   i_d_pc      : PC of the D instruction
//   i_cmp_reg   : rs vs rt compare code
//   i_cmp_zero  : rs vs 0 compare code
//   i_imm       : branch offset (words, signed)
//   i_index     : jump index
//   i_rs_value  : forwarded rs for jump-register
//   o_taken     : redirect is taken this cycle
//   o_target    : redirect address (meaningful only when o_taken)
// ---------------------------------------------------------------------------
module npc_target
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_enable,
    input  logic [3:0]        i_pcsel,
    input  logic [ADDR_W-1:0] i_d_pc,
    input  logic [1:0]        i_cmp_reg,
    input  logic [1:0]        i_cmp_zero,
    input  logic [15:0]       i_imm,
    input  logic [25:0]       i_index,
    input  logic [ADDR_W-1:0] i_rs_value,
    output logic              o_taken,
    output logic [ADDR_W-1:0] o_target
);

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_j_target;
    logic              w_cond;

    assign w_pc_plus4  = i_d_pc + FOUR;
    assign w_br_off    = {{(ADDR_W-18){i_imm[15]}}, i_imm, 2'b00};
    assign w_br_target = w_pc_plus4 + w_br_off;
    // Jump keeps the upper region bits of the delay-slot address.
    assign w_j_target  = {w_pc_plus4[ADDR_W-1:28], i_index, 2'b00};

    always_comb begin
        w_cond   = 1'b0;
        o_target = w_br_target;
        case (i_pcsel)
            PCSEL_BEQ:  w_cond = (i_cmp_reg == CMP_EQUAL);
            PCSEL_BNE:  w_cond = (i_cmp_reg != CMP_EQUAL);
            PCSEL_BGEZ: w_cond = (i_cmp_zero != CMP_LESS);
            PCSEL_BGTZ: w_cond = (i_cmp_zero == CMP_BIG);
            PCSEL_BLEZ: w_cond = (i_cmp_zero != CMP_BIG);
            PCSEL_BLTZ: w_cond = (i_cmp_zero == CMP_LESS);
            PCSEL_JUMP: begin
                w_cond   = 1'b1;
                o_target = w_j_target;
            end
            PCSEL_JREG: begin
                w_cond   = 1'b1;
                o_target = i_rs_value;
            end
            default:    w_cond = 1'b0;
        endcase
    end

    assign o_taken = i_enable & w_cond;

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit : fetch-stage program counter.
//   clk, reset     : rising-edge clock, synchronous active-low reset
//   F_stall        : hazard freeze of F/D
//   F_ready        : instruction memory returns data for F_PC
//   F_req          : fetch request for F_PC (high whenever out of reset)
//   F_PC           : current fetch address
//   F_valid        : instruction at F_PC completes and may enter D
//   F_AdEL         : F_PC misaligned or outside the legal fetch window
//   D_*            : D-stage branch/jump resolution inputs
//   exc_req/eret_req/EPC : CP0 redirections
//   dbg_pend_v/dbg_pend_pc : pending-redirect buffer state
//
// Handshake: a fetch completes on any cycle with F_req & F_ready; it is
// consumed only when F_stall is low, otherwise memory re-presents the data.
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] EXC_PC   = 32'h0000_4180,
    parameter logic [ADDR_W-1:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              F_stall,
    input  logic              F_ready,
    output logic              F_req,
    output logic [ADDR_W-1:0] F_PC,
    output logic              F_valid,
    output logic              F_AdEL,
    input  logic              D_valid,
    input  logic [3:0]        D_PCsel,
    input  logic [ADDR_W-1:0] D_PC,
    input  logic [1:0]        D_cmpReg,
    input  logic [1:0]        D_cmpZero,
    input  logic [15:0]       D_imm,
    input  logic [25:0]       D_index,
    input  logic [ADDR_W-1:0] D_rsValue,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] EPC,
    output logic              dbg_pend_v,
    output logic [ADDR_W-1:0] dbg_pend_pc
);

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pend_v;
    logic [ADDR_W-1:0] r_pend_pc;

    logic              w_done;
    logic              w_adv;
    logic              w_taken;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_next_pc;

    npc_target #(.ADDR_W(ADDR_W)) u_npc (
        .i_enable   (D_valid & ~F_stall),
        .i_pcsel    (D_PCsel),
        .i_d_pc     (D_PC),
        .i_cmp_reg  (D_cmpReg),
        .i_cmp_zero (D_cmpZero),
        .i_imm      (D_imm),
        .i_index    (D_index),
        .i_rs_value (D_rsValue),
        .o_taken    (w_taken),
        .o_target   (w_target)
    );

    assign F_req  = reset;
    assign w_done = F_req & F_ready;
    assign w_adv  = w_done & ~F_stall;

    always_comb begin
        w_next_pc = r_pc;
        if (exc_req)                w_next_pc = EXC_PC;
        else if (eret_req)          w_next_pc = EPC;
        else if (w_adv & r_pend_v)  w_next_pc = r_pend_pc;
        else if (w_adv & w_taken)   w_next_pc = w_target;
        else if (w_adv)             w_next_pc = r_pc + FOUR;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_pend_v  <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (exc_req | eret_req) begin
                r_pend_v <= 1'b0;
            end else if (w_adv) begin
                r_pend_v <= 1'b0;
            end else if (w_taken) begin
                // Delay slot still outstanding: remember where to go after it.
                r_pend_v  <= 1'b1;
                r_pend_pc <= w_target;
            end
        end
    end

    assign F_PC        = r_pc;
    assign F_valid     = w_adv & ~exc_req & ~eret_req;
    assign F_AdEL      = (r_pc[1:0] != 2'b00) | (r_pc < IMEM_LO) | (r_pc > IMEM_HI);
    assign dbg_pend_v  = r_pend_v;
    assign dbg_pend_pc = r_pend_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        F_stall, F_ready, F_req, F_valid, F_AdEL;
    logic [31:0] F_PC;
    logic        D_valid;
    logic [3:0]  D_PCsel;
    logic [31:0] D_PC, D_rsValue, EPC;
    logic [1:0]  D_cmpReg, D_cmpZero;
    logic [15:0] D_imm;
    logic [25:0] D_index;
    logic        exc_req, eret_req;
    logic        dbg_pend_v;
    logic [31:0] dbg_pend_pc;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .F_stall(F_stall), .F_ready(F_ready),
        .F_req(F_req), .F_PC(F_PC), .F_valid(F_valid), .F_AdEL(F_AdEL),
        .D_valid(D_valid), .D_PCsel(D_PCsel), .D_PC(D_PC),
        .D_cmpReg(D_cmpReg), .D_cmpZero(D_cmpZero), .D_imm(D_imm),
        .D_index(D_index), .D_rsValue(D_rsValue), .exc_req(exc_req),
        .eret_req(eret_req), .EPC(EPC), .dbg_pend_v(dbg_pend_v),
        .dbg_pend_pc(dbg_pend_pc)
    );

    always #5 clk = ~clk;

    function automatic logic model_adel(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
    endfunction

    function automatic logic model_taken(input logic [3:0] sel, input logic [1:0] cr,
                                         input logic [1:0] cz);
        case (sel)
            4'd1: return cr == 2'b00;
            4'd2: return cr != 2'b00;
            4'd3: return cz != 2'b10;
            4'd4: return cz == 2'b01;
            4'd5: return cz != 2'b01;
            4'd6: return cz == 2'b10;
            4'd7, 4'd8: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // A second taken redirect while one is buffered must never be driven.
    always @(posedge clk) begin
        if (reset && dbg_pend_v && D_valid && !F_stall &&
            model_taken(D_PCsel, D_cmpReg, D_cmpZero)) begin
            n_err++;
            $display("FAIL protocol: taken redirect with pend_v=1 at %0t", $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        F_stall = 0; F_ready = 1; D_valid = 0; D_PCsel = 4'd0; D_PC = 0;
        D_cmpReg = 2'b11; D_cmpZero = 2'b11; D_imm = 0; D_index = 0;
        D_rsValue = 0; exc_req = 0; eret_req = 0; EPC = 0;
    endtask

    // Check combinational outputs for the current inputs, then the
    // registered state after the next edge via the expected queue.
    task automatic cyc(input string name, input logic exp_valid, input logic exp_pend,
                       input logic [31:0] exp_pc);
        logic [32:0] e;
        #1;
        chk({name, " F_valid"}, {31'd0, F_valid}, {31'd0, exp_valid});
        exp_q.push_back({exp_pend, exp_pc});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({name, " F_PC"}, F_PC, e[31:0]);
        chk({name, " pend_v"}, {31'd0, dbg_pend_v}, {31'd0, e[32]});
        chk({name, " F_AdEL"}, {31'd0, F_AdEL}, {31'd0, model_adel(e[31:0])});
    endtask

    task automatic load_pc(input logic [31:0] pc);
        set_idle();
        eret_req = 1; EPC = pc;
        cyc("load", 1'b0, 1'b0, pc);
        set_idle();
    endtask

    typedef struct {
        logic        dval;
        logic [3:0]  sel;
        logic [1:0]  cr;
        logic [1:0]  cz;
        logic [31:0] dpc;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // Starting PC for every vector is 0x3400; sequential next is 0x3404.
        tbl[0]  = '{1'b1, 4'd0, 2'b00, 2'b00, 32'h3004, 16'h0003, 26'h0, 32'h0, 32'h3404};
        tbl[1]  = '{1'b1, 4'd1, 2'b00, 2'b01, 32'h3004, 16'h0003, 26'h0, 32'h0, 32'h3014};
        tbl[2]  = '{1'b1, 4'd1, 2'b01, 2'b00, 32'h3004, 16'h0003, 26'h0, 32'h0, 32'h3404};
        tbl[3]  = '{1'b1, 4'd2, 2'b10, 2'b00, 32'h3100, 16'hFFFF, 26'h0, 32'h0, 32'h3100};
        tbl[4]  = '{1'b1, 4'd2, 2'b00, 2'b10, 32'h3100, 16'hFFFF, 26'h0, 32'h0, 32'h3404};
        tbl[5]  = '{1'b1, 4'd3, 2'b10, 2'b01, 32'h3200, 16'h0010, 26'h0, 32'h0, 32'h3244};
        tbl[6]  = '{1'b1, 4'd3, 2'b00, 2'b10, 32'h3200, 16'h0010, 26'h0, 32'h0, 32'h3404};
        tbl[7]  = '{1'b1, 4'd4, 2'b00, 2'b01, 32'h3000, 16'h0001, 26'h0, 32'h0, 32'h3008};
        tbl[8]  = '{1'b1, 4'd4, 2'b01, 2'b00, 32'h3000, 16'h0001, 26'h0, 32'h0, 32'h3404};
        tbl[9]  = '{1'b1, 4'd5, 2'b01, 2'b00, 32'h3300, 16'hFFFE, 26'h0, 32'h0, 32'h32FC};
        tbl[10] = '{1'b1, 4'd5, 2'b00, 2'b01, 32'h3300, 16'hFFFE, 26'h0, 32'h0, 32'h3404};
        tbl[11] = '{1'b1, 4'd6, 2'b00, 2'b10, 32'h3500, 16'h0002, 26'h0, 32'h0, 32'h350C};
        tbl[12] = '{1'b1, 4'd6, 2'b10, 2'b00, 32'h3500, 16'h0002, 26'h0, 32'h0, 32'h3404};
        tbl[13] = '{1'b1, 4'd7, 2'b01, 2'b01, 32'hF000_1000, 16'h0, 26'h1000, 32'h0, 32'hF000_4000};
        tbl[14] = '{1'b1, 4'd8, 2'b01, 2'b01, 32'h3004, 16'h0, 26'h0, 32'h3100, 32'h3100};
        tbl[15] = '{1'b1, 4'd8, 2'b01, 2'b01, 32'h3004, 16'h0, 26'h0, 32'h3102, 32'h3102};
        tbl[16] = '{1'b0, 4'd1, 2'b00, 2'b00, 32'h3004, 16'h0003, 26'h0, 32'h0, 32'h3404};

        // Reset state
        set_idle();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst F_req", {31'd0, F_req}, 32'd0);
        chk("rst F_valid", {31'd0, F_valid}, 32'd0);
        chk("rst F_PC", F_PC, 32'h3000);
        chk("rst pend_v", {31'd0, dbg_pend_v}, 32'd0);
        chk("rst pend_pc", dbg_pend_pc, 32'd0);
        chk("rst F_AdEL", {31'd0, F_AdEL}, 32'd0);
        reset = 1;
        #1;
        chk("run F_req", {31'd0, F_req}, 32'd1);
        cyc("seq0", 1'b1, 1'b0, 32'h3004);
        cyc("seq1", 1'b1, 1'b0, 32'h3008);

        // beq taken with fetch ready at 0x3008
        D_valid = 1; D_PCsel = 4'd1; D_PC = 32'h3004; D_imm = 16'h0003; D_cmpReg = 2'b00;
        cyc("beq", 1'b1, 1'b0, 32'h3014);

        // Selector table
        for (int i = 0; i < 17; i++) begin
            load_pc(32'h3400);
            D_valid = tbl[i].dval; D_PCsel = tbl[i].sel; D_cmpReg = tbl[i].cr;
            D_cmpZero = tbl[i].cz; D_PC = tbl[i].dpc; D_imm = tbl[i].imm;
            D_index = tbl[i].idx; D_rsValue = tbl[i].rs;
            cyc($sformatf("vec%0d", i), 1'b1, 1'b0, tbl[i].exp);
        end

        // jr while the delay slot fetch is waiting
        load_pc(32'h3008);
        F_ready = 0; D_valid = 1; D_PCsel = 4'd8; D_rsValue = 32'h3100;
        cyc("jrw0", 1'b0, 1'b1, 32'h3008);
        chk("jrw pend_pc", dbg_pend_pc, 32'h3100);
        D_valid = 0;
        cyc("jrw1", 1'b0, 1'b1, 32'h3008);
        cyc("jrw2", 1'b0, 1'b1, 32'h3008);
        F_ready = 1;
        cyc("jrw_apply", 1'b1, 1'b0, 32'h3100);

        // exc + eret together with a pending buffer
        load_pc(32'h3008);
        F_ready = 0; D_valid = 1; D_PCsel = 4'd8; D_rsValue = 32'h3100;
        cyc("exc_pend", 1'b0, 1'b1, 32'h3008);
        set_idle();
        exc_req = 1; eret_req = 1; EPC = 32'h3200;
        cyc("exc_eret", 1'b0, 1'b0, 32'h4180);
        set_idle();
        cyc("exc_next", 1'b1, 1'b0, 32'h4184);

        // Address window edges and wrap
        load_pc(32'h7000);
        F_ready = 0;
        cyc("hold7000", 1'b0, 1'b0, 32'h7000);
        load_pc(32'h6FFC);
        load_pc(32'h2FFC);
        load_pc(32'hFFFF_FFFC);
        cyc("wrap", 1'b1, 1'b0, 32'h0);

        // Stall holds PC and buffer even with F_ready=1
        load_pc(32'h3008);
        F_stall = 1; F_ready = 1; D_valid = 1; D_PCsel = 4'd2; D_cmpReg = 2'b10;
        D_PC = 32'h3004; D_imm = 16'h0004;
        cyc("stall0", 1'b0, 1'b0, 32'h3008);
        cyc("stall1", 1'b0, 1'b0, 32'h3008);
        F_stall = 0;
        cyc("stall_rel", 1'b1, 1'b0, 32'h3018);

        // Reset with a buffer pending discards it
        load_pc(32'h3008);
        F_ready = 0; D_valid = 1; D_PCsel = 4'd8; D_rsValue = 32'h3100;
        cyc("rstp_pend", 1'b0, 1'b1, 32'h3008);
        set_idle();
        reset = 0;
        cyc("rst_mid", 1'b0, 1'b0, 32'h3000);
        chk("rst_mid pend_pc", dbg_pend_pc, 32'd0);
        reset = 1;
        cyc("after_rst", 1'b1, 1'b0, 32'h3004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
